// File: rtl/branch_redirect_pc.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_pc
// Purpose  : Fetch PC unit; applies taken branches/jumps with a timed flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_pc #(
    parameter int ADDR_W       = 10,
    parameter int FLUSH_CYCLES = 2,
    parameter int RESET_PC     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              halted,
    output logic [7:0]        redirect_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0]        C_FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] C_RESET_PC   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] C_PC_ONE     = ADDR_W'(1);

    state_t            state_q;
    logic [2:0]        fcnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              flush_q;
    logic              halted_q;
    logic [7:0]        cnt_q;

    logic [ADDR_W-1:0] seq_pc_d;
    logic              br_take_d;
    logic              redirect_d;
    logic [ADDR_W-1:0] target_d;
    logic [7:0]        cnt_d;

    assign seq_pc_d   = stall ? pc_q : pc_q + C_PC_ONE;
    assign br_take_d  = br_valid & br_taken;
    assign redirect_d = br_take_d | jmp_valid;
    assign target_d   = br_take_d ? br_target : jmp_target;
    assign cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fcnt_q     <= 3'd0;
            pc_q       <= C_RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // First edge after reset only makes RESET_PC live; it does not advance.
                    if (!pc_valid_q) begin
                        pc_valid_q <= 1'b1;
                    end else if (halt) begin
                        state_q    <= ST_HALTED;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (redirect_d) begin
                        pc_q    <= target_d;
                        flush_q <= 1'b1;
                        fcnt_q  <= C_FLUSH_LAST;
                        state_q <= ST_FLUSH;
                        cnt_q   <= cnt_d;
                    end else begin
                        pc_q <= seq_pc_d;
                    end
                end
                ST_FLUSH: begin
                    // Control inputs here come from squashed instructions.
                    pc_q <= seq_pc_d;
                    if (fcnt_q == 3'd0) begin
                        flush_q <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        fcnt_q <= fcnt_q - 3'd1;
                    end
                end
                ST_HALTED: begin
                    pc_valid_q <= 1'b0;
                    flush_q    <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign flush        = flush_q;
    assign halted       = halted_q;
    assign redirect_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_pc
// Purpose  : Vector table plus scoreboard bench for branch_redirect_pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_pc;

    localparam int ADDR_W = 10;

    typedef struct {
        logic              rst, stall, brv, brt;
        logic [ADDR_W-1:0] brtgt;
        logic              jv;
        logic [ADDR_W-1:0] jtgt;
        logic              halt;
        logic [ADDR_W-1:0] epc;
        logic              epv, efl, eh;
        logic [7:0]        ecnt;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              pv, fl, h;
        logic [7:0]        cnt;
        string             name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              jmp_valid = 1'b0;
    logic [ADDR_W-1:0] jmp_target = '0;
    logic              halt = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic              halted;
    logic [7:0]        redirect_cnt;

    int   total = 0;
    int   bad   = 0;
    vec_t vt[64];
    int   nv    = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    branch_redirect_pc #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halt(halt),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .halted(halted),
        .redirect_cnt(redirect_cnt)
    );

    task automatic add(input logic r, input logic s, input logic bv, input logic bt,
                       input logic [ADDR_W-1:0] btg, input logic jv, input logic [ADDR_W-1:0] jtg,
                       input logic h, input logic [ADDR_W-1:0] epc, input logic epv,
                       input logic efl, input logic eh, input logic [7:0] ecnt);
        vt[nv] = '{r, s, bv, bt, btg, jv, jtg, h, epc, epv, efl, eh, ecnt};
        nv++;
    endtask

    // Drive one cycle of inputs, queue its expectation, then check after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = v.rst; stall = v.stall; br_valid = v.brv; br_taken = v.brt;
        br_target = v.brtgt; jmp_valid = v.jv; jmp_target = v.jtgt; halt = v.halt;
        e = '{v.epc, v.epv, v.efl, v.eh, v.ecnt, name};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        total++;
        if (pc !== got.pc || pc_valid !== got.pv || flush !== got.fl ||
            halted !== got.h || redirect_cnt !== got.cnt) begin
            bad++;
            $display("FAIL %s: got pc=%h pv=%b fl=%b h=%b cnt=%0d, want pc=%h pv=%b fl=%b h=%b cnt=%0d",
                     got.name, pc, pc_valid, flush, halted, redirect_cnt,
                     got.pc, got.pv, got.fl, got.h, got.cnt);
        end
    endtask

    initial begin
        vec_t v;
        logic [ADDR_W-1:0] tgt;
        int exp_cnt;

        //   rst s bv bt brtgt    jv jtgt     h  epc      pv fl h  cnt
        add(1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h001, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h002, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h003, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h004, 1, 0, 0, 8'd0);
        add(0, 0, 1, 1, 10'h120, 0, 10'h000, 0, 10'h120, 1, 1, 0, 8'd1);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h121, 1, 1, 0, 8'd1);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h122, 1, 0, 0, 8'd1);
        add(0, 0, 1, 0, 10'h050, 0, 10'h000, 0, 10'h123, 1, 0, 0, 8'd1);
        add(0, 0, 0, 1, 10'h200, 0, 10'h000, 0, 10'h124, 1, 0, 0, 8'd1);
        add(0, 0, 0, 0, 10'h000, 1, 10'h010, 0, 10'h010, 1, 1, 0, 8'd2);
        add(0, 0, 1, 1, 10'h300, 0, 10'h000, 0, 10'h011, 1, 1, 0, 8'd2);
        add(0, 0, 0, 0, 10'h000, 1, 10'h200, 0, 10'h012, 1, 0, 0, 8'd2);
        add(0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 0, 0, 8'd2);
        add(0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 0, 0, 8'd2);
        add(0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 0, 0, 8'd2);
        add(0, 1, 0, 0, 10'h000, 1, 10'h3FF, 0, 10'h3FF, 1, 1, 0, 8'd3);
        add(0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h3FF, 1, 1, 0, 8'd3);
        add(0, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h3FF, 1, 0, 0, 8'd3);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 8'd3);
        for (int i = 1; i <= 7; i++)
            add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, ADDR_W'(i), 1, 0, 0, 8'd3);
        add(0, 0, 0, 0, 10'h000, 1, 10'h055, 1, 10'h007, 0, 0, 1, 8'd3);
        add(0, 0, 1, 1, 10'h100, 0, 10'h000, 0, 10'h007, 0, 0, 1, 8'd3);
        add(0, 1, 0, 0, 10'h000, 1, 10'h066, 0, 10'h007, 0, 0, 1, 8'd3);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 1, 10'h007, 0, 0, 1, 8'd3);
        add(1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h001, 1, 0, 0, 8'd0);
        add(0, 0, 1, 1, 10'h080, 0, 10'h000, 0, 10'h080, 1, 1, 0, 8'd1);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h081, 1, 1, 0, 8'd1);
        add(1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 8'd0);
        add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h001, 1, 0, 0, 8'd0);
        add(0, 1, 1, 0, 10'h2AA, 0, 10'h000, 0, 10'h001, 1, 0, 0, 8'd0);

        for (int i = 0; i < nv; i++)
            apply(vt[i], $sformatf("vec%0d", i));

        // Saturation: 260 taken branches, each followed by the two flush cycles.
        v = '{1, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0, 0, 8'd0};
        apply(v, "sat_rst");
        v = '{0, 0, 0, 0, '0, 0, '0, 0, '0, 1, 0, 0, 8'd0};
        apply(v, "sat_prime");
        for (int i = 0; i < 260; i++) begin
            tgt     = ADDR_W'(i * 3 + 16);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            v = '{0, 0, 1, 1, tgt, 0, '0, 0, tgt, 1, 1, 0, 8'(exp_cnt)};
            apply(v, $sformatf("sat_br%0d", i));
            v = '{0, 0, 0, 0, '0, 0, '0, 0, tgt + 10'd1, 1, 1, 0, 8'(exp_cnt)};
            apply(v, $sformatf("sat_f1_%0d", i));
            v = '{0, 0, 0, 0, '0, 0, '0, 0, tgt + 10'd2, 1, 0, 0, 8'(exp_cnt)};
            apply(v, $sformatf("sat_f2_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_redirect_pc.md
Name: branch_redirect_pc

Overview:
- Fetch-side program-counter unit directly downstream of the branch equality comparator.
- Consumes the comparator's taken/not-taken result (`s`) for the branch in EX, together with the branch target.
- Drives the fetch address, and squashes the younger in-flight instructions with a timed flush when a redirect occurs.
- Also handles unconditional jumps, pipeline stalls and the halt instruction.

Parameters:
- ADDR_W, 10, width of PC and targets.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- stall  input  1  hazard stall; hold the PC.
- br_valid  input  1  EX stage holds a conditional branch this cycle.
- br_taken  input  1  comparator output `s`; qualified by br_valid.
- br_target  input  ADDR_W  branch target address.
- jmp_valid  input  1  EX stage holds an unconditional jump.
- jmp_target  input  ADDR_W  jump target.
- halt  input  1  EX stage holds a halt.
- pc  output  ADDR_W  current fetch address (registered).
- pc_valid  output  1  pc is a live fetch this cycle.
- flush  output  1  squash the IF/ID stage contents (registered).
- halted  output  1  core stopped.
- redirect_cnt  output  8  saturating count of redirects taken.

Behaviour:
- The design has one clock; reset is synchronous and active-high (clk, rst).
- Reset values (rst high at an edge):
  - pc=RESET_PC, pc_valid=0, flush=0, halted=0, redirect_cnt=0.
  - State=RUN, flush counter=0.
  - Reset has priority over every other input in every state, including mid-FLUSH and HALTED.
- States: RUN, FLUSH, HALTED.
- First cycle after reset release: pc_valid=1, pc=RESET_PC.
- RUN, evaluated each edge in strict priority order:
  1. halt=1: state→HALTED; pc holds; pc_valid→0; halted→1.
  2. br_valid & br_taken: pc←br_target; flush→1; counter←FLUSH_CYCLES-1; state→FLUSH; redirect_cnt+1.
  3. jmp_valid: same as (2) but with jmp_target.
  4. stall=1: pc holds.
  5. Otherwise: pc←pc+1, modulo 2^ADDR_W (wraps to 0).
- Redirect overrides stall: a redirect in the same cycle as stall=1 still loads the target.
- br_taken is ignored when br_valid=0.
- br_valid & !br_taken: behaves as (4)/(5), with no flush and no count.
- Redirect latency:
  - Target appears on pc 1 cycle after the redirect edge.
  - flush rises in that same cycle and stays high for exactly FLUSH_CYCLES cycles.
- FLUSH:
  - br_valid, jmp_valid and halt are ignored, because they originate from squashed instructions.
  - pc advances per (4)/(5), so fetch from the target proceeds or stalls normally.
  - pc_valid stays 1.
  - When counter=0, at the next edge: flush→0, state→RUN; otherwise counter decrements.
- HALTED:
  - pc frozen, pc_valid=0, flush=0, halted=1.
  - All inputs except rst are ignored.
- redirect_cnt: saturates at 255; no wrap.
- Outputs are pure register outputs; there is no combinational input→output path.

Test Plan:
- Reset/increment: rst high 2 cycles, RESET_PC=0, then 5 idle cycles → pc=0,1,2,3,4; pc_valid=1 from first post-reset cycle; flush=0.
- Taken branch: at pc=4 drive br_valid=1, br_taken=1, br_target=0x120 for 1 cycle.
  - → next cycle pc=0x120, flush=1 for exactly 2 cycles, redirect_cnt=1.
  - → pc=0x121,0x122 during the flush cycles.
- Not-taken and squashed branch:
  - br_valid=1, br_taken=0 → pc increments, flush stays 0, count unchanged.
  - A taken branch or jmp asserted during the FLUSH window → ignored; pc keeps incrementing.
- Stall vs redirect:
  - stall=1 for 3 cycles → pc constant.
  - stall=1 with jmp_valid=1, jmp_target=0x3FF → pc=0x3FF next cycle.
  - Then, once the flush window ends and stall is released, pc=0x3FF→0x000 (wrap).
- Halt and reset mid-operation:
  - halt=1 at pc=7 → pc stays 7, pc_valid=0, halted=1 permanently despite br/jmp/stall activity.
  - rst during HALTED → pc=RESET_PC, halted=0.
  - rst during the second flush cycle → flush=0 and state RUN next cycle.
- Counter saturation: 260 back-to-back taken branches, each separated by FLUSH_CYCLES idle cycles → redirect_cnt stops at 255.
